// File: rtl/seq_divider_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
//   state_e : divider FSM states (IDLE, RUN, DONE)
//   DIV_W   : default operand width
//   DIV_CW  : iteration counter width for DIV_W
package div_pkg;
   localparam int DIV_W  = 32;
   localparam int DIV_CW = $clog2(DIV_W);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result bundle between the ALU and the divider.
//   start, dividend, divisor          : request, driven by the master
//   busy, done, quotient, remainder,
//   div_by_zero                       : status and results, driven by the divider
//   is_signed                         : operand signedness, present only with SEQ_DIV_SIGNED_EN
interface seq_divider_if
   import div_pkg::*;
#(
   parameter int W = DIV_W
);
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;
`ifdef SEQ_DIV_SIGNED_EN
   logic         is_signed;
   modport master (output start, dividend, divisor, is_signed,
                   input  busy, done, quotient, remainder, div_by_zero);
   modport slave  (input  start, dividend, divisor, is_signed,
                   output busy, done, quotient, remainder, div_by_zero);
`else
   modport master (output start, dividend, divisor,
                   input  busy, done, quotient, remainder, div_by_zero);
   modport slave  (input  start, dividend, divisor,
                   output busy, done, quotient, remainder, div_by_zero);
`endif
endinterface

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem_i     : partial remainder before this step
//   bit_i     : next dividend bit shifted into the remainder
//   divisor_i : denominator
//   rem_o     : partial remainder after this step
//   q_o       : quotient bit produced by this step
module div_step
   import div_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic [W-1:0] rem_i,
   input  logic         bit_i,
   input  logic [W-1:0] divisor_i,
   output logic [W-1:0] rem_o,
   output logic         q_o
);
   // One bit wider than the remainder so the shifted value never overflows the trial compare.
   logic [W:0] shifted;
   assign shifted = {rem_i, bit_i};
   assign q_o     = shifted >= {1'b0, divisor_i};
   // When the subtraction succeeds the difference is below the divisor, so W bits hold it.
   assign rem_o   = q_o ? shifted[W-1:0] - divisor_i : shifted[W-1:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock, W+1 cycle latency.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; discards any division in flight
//   bus   : seq_divider_if slave (start/operands in, busy/done/results out)
// Build option SEQ_DIV_SIGNED_EN adds bus.is_signed for two's-complement operands.
module seq_divider
   import div_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic         clk,
   input  logic         rst_n,
   seq_divider_if.slave bus
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   state_e        state_q, state_d;
   logic [W-1:0]  rem_q, rem_d;
   logic [W-1:0]  quo_q, quo_d;
   logic [W-1:0]  dvs_q, dvs_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          zero_q, zero_d;
   logic [W-1:0]  quot_q, quot_d;
   logic [W-1:0]  remo_q, remo_d;
   logic          dbz_q, dbz_d;
   logic [W-1:0]  step_rem, q_next, dvd_in, dvs_in, q_fix, r_fix;
   logic          step_q;
`ifdef SEQ_DIV_SIGNED_EN
   logic          qneg_q, qneg_d, rneg_q, rneg_d;
`endif

   // The quotient register doubles as the dividend shifter: its MSB feeds the step,
   // and the new quotient bit enters at the LSB.
   div_step #(.W(W)) u_step (
      .rem_i     (rem_q),
      .bit_i     (quo_q[W-1]),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .q_o       (step_q)
   );

   assign q_next = {quo_q[W-2:0], step_q};

`ifdef SEQ_DIV_SIGNED_EN
   // The core divides magnitudes; signs are restored when results are latched.
   assign dvd_in = (bus.is_signed && bus.dividend[W-1]) ? -bus.dividend : bus.dividend;
   assign dvs_in = (bus.is_signed && bus.divisor[W-1]) ? -bus.divisor : bus.divisor;
   // Divide by zero keeps the all-ones quotient regardless of operand signs.
   assign q_fix  = zero_q ? '1 : (qneg_q ? -q_next : q_next);
   assign r_fix  = rneg_q ? -step_rem : step_rem;
`else
   assign dvd_in = bus.dividend;
   assign dvs_in = bus.divisor;
   assign q_fix  = q_next;
   assign r_fix  = step_rem;
`endif

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      dbz_d   = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
`endif
      unique case (state_q)
         RUN: begin
            rem_d = step_rem;
            quo_d = q_next;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = DONE;
               quot_d  = q_fix;
               remo_d  = r_fix;
               dbz_d   = zero_q;
            end
         end
         // IDLE and DONE both accept a new request, giving back-to-back issue.
         default: begin
            state_d = IDLE;
            if (bus.start) begin
               state_d = RUN;
               rem_d   = '0;
               quo_d   = dvd_in;
               dvs_d   = dvs_in;
               cnt_d   = CW'(W - 1);
               zero_d  = bus.divisor == '0;
`ifdef SEQ_DIV_SIGNED_EN
               qneg_d  = bus.is_signed & (bus.dividend[W-1] ^ bus.divisor[W-1]);
               rneg_d  = bus.is_signed & bus.dividend[W-1];
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
         quot_q  <= '0;
         remo_q  <= '0;
         dbz_q   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         dbz_q   <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
`endif
      end
   end

   assign bus.busy        = state_q == RUN;
   assign bus.done        = state_q == DONE;
   assign bus.quotient    = quot_q;
   assign bus.remainder   = remo_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider (unsigned; signed cases with SEQ_DIV_SIGNED_EN).
module tb_seq_divider;
   localparam int W   = 32;
   localparam int LAT = W + 1;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           c;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   tests = 0;
   int   errs  = 0;
   exp_t sb[$];

   seq_divider_if #(.W(W)) bus ();
   seq_divider #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg, input int c);
      exp_t e;
      int   sa, sbv;
      e.c = c;
      e.z = (b == '0);
      sa  = a;
      sbv = b;
      if (b == '0) begin
         e.q = '1;
         e.r = a;
      end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.q = a;
         e.r = '0;
      end else if (sg) begin
         e.q = sa / sbv;
         e.r = sa % sbv;
      end else begin
         e.q = a / b;
         e.r = a % b;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.done) begin : mon
         exp_t e;
         chk("done_pending", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("quotient", bus.quotient, e.q);
            chk("remainder", bus.remainder, e.r);
            chk("div_by_zero", bus.div_by_zero, e.z);
            chk("latency", cyc - e.c, LAT);
            chk("busy_at_done", bus.busy, 0);
         end
      end
   end

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
`ifdef SEQ_DIV_SIGNED_EN
      bus.is_signed = sg;
`endif
   endtask

   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
      @(negedge clk);
      drive(a, b, sg);
      sb.push_back(model(a, b, sg, cyc));
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy", bus.busy, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 4 * LAT && sb.size() > 0; i++) @(negedge clk);
      chk("drained", sb.size(), 0);
   endtask

   initial begin
      int c1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
`ifdef SEQ_DIV_SIGNED_EN
      bus.is_signed = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_quotient", bus.quotient, 0);
      chk("rst_remainder", bus.remainder, 0);
      chk("rst_dbz", bus.div_by_zero, 0);
      rst_n = 1'b1;

      run_div(32'd100, 32'd7, 1'b0);
      drain();
      run_div(32'hFFFF_FFFF, 32'd1, 1'b0);
      drain();
      run_div(32'd5, 32'hFFFF_FFFF, 1'b0);
      drain();
      run_div(32'd1234, 32'd0, 1'b0);
      drain();
      for (int i = 0; i < 6; i++) begin
         run_div($urandom, (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom, 1'b0);
         drain();
      end

      // A request during RUN must be dropped without disturbing the result.
      run_div(32'd1000, 32'd9, 1'b0);
      repeat (3) @(negedge clk);
      drive(32'd77, 32'd5, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;
      drain();

      // Start held high through DONE: the second divide starts in the DONE cycle.
      @(negedge clk);
      drive(32'd50_000, 32'd13, 1'b0);
      c1 = cyc;
      sb.push_back(model(32'd50_000, 32'd13, 1'b0, c1));
      @(negedge clk);
      drive(32'd987_654, 32'd321, 1'b0);
      repeat (LAT - 1) @(negedge clk);
      sb.push_back(model(32'd987_654, 32'd321, 1'b0, cyc));
      @(negedge clk);
      bus.start = 1'b0;
      drain();

      // Reset in the middle of RUN clears everything at once.
      run_div(32'd500, 32'd3, 1'b0);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_done", bus.done, 0);
      chk("mid_rst_quotient", bus.quotient, 0);
      chk("mid_rst_remainder", bus.remainder, 0);
      chk("mid_rst_dbz", bus.div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_div(32'd9, 32'd3, 1'b0);
      drain();

`ifdef SEQ_DIV_SIGNED_EN
      run_div(-32'sd7, 32'd2, 1'b1);
      drain();
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      drain();
      run_div(-32'sd1234, 32'd0, 1'b1);
      drain();
      run_div(32'd100, -32'sd7, 1'b1);
      drain();
      run_div(32'hFFFF_FFF0, 32'd3, 1'b0);
      drain();
`endif

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end
endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle restoring integer divider for the RISC datapath, the inverse counterpart of the combinational array multiplier in the ALU. It accepts a dividend/divisor pair on a start pulse, iterates one quotient bit per clock, and returns quotient and remainder with a single-cycle done strobe. The ALU stalls on `busy` while a division is in flight.

## Interface
- `W`, 32: operand width; quotient and remainder are also `W` bits.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request; sampled only when `busy`=0.
- `dividend` in W: numerator, captured on accepted `start`.
- `divisor` in W: denominator, captured on accepted `start`.
- `busy` out 1: division in progress; new `start` ignored.
- `done` out 1: one-cycle pulse; results valid this cycle.
- `quotient` out W: result, held until next accepted `start`.
- `remainder` out W: result, held until next accepted `start`.
- `div_by_zero` out 1: divisor was 0; valid and held with results.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: on `start`=1, capture operands into internal registers, clear partial remainder, load iteration counter with W-1, go RUN. Outputs keep their previous values until DONE.
- RUN: each cycle, shift {rem, quo} left by one, trial-subtract divisor from rem; if no borrow, keep difference and set quo LSB=1, else restore and set LSB=0. Partial remainder is W+1 bits wide to hold the borrow. Counter decrements; at 0, go DONE.
- DONE: drive results onto `quotient`/`remainder`, pulse `done`, return to IDLE.
- `start` accepted whenever `busy`=0, including the DONE cycle. Start in DONE goes straight to RUN.
- Divide by zero: no fast path. The iteration naturally yields `quotient`=all ones and `remainder`=dividend, and `div_by_zero`=1.
- `start` while `busy`=1 is ignored. No queueing.
- Reset, including mid-RUN: state IDLE, and all outputs (`busy`, `done`, `quotient`, `remainder`, `div_by_zero`) are 0. Any in-flight operation is discarded.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycles 1..W: `busy`=1 (RUN, W iterations).
- Cycle W+1: `done`=1, `busy`=0, results valid.
- Total latency is W+1 cycles from accept to `done`, fixed and independent of operand values.
- Back-to-back throughput is one result per W+1 cycles when `start` is held high.
- `busy` and `done` are registered, never combinational from `start`.

## Configuration
- Macro: `SEQ_DIV_SIGNED_EN`.
- Defined:
  - Adds input `is_signed` (1 bit), captured with the operands.
  - When `is_signed`=1, operands are two's complement. The core divides magnitudes, then fixes signs in DONE.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Overflow case -2^(W-1) / -1 gives `quotient`=-2^(W-1), `remainder`=0.
  - Divide by zero still gives all-ones quotient and `remainder`=dividend.
- Undefined: the `is_signed` port is absent and all operation is unsigned. Latency is identical in both builds.

## Structure
- Package `div_pkg` holds:
  - the FSM state enum (IDLE/RUN/DONE);
  - the default width constant `DIV_W`=32;
  - the counter width `$clog2(DIV_W)`.
- Sub-module `div_step`: combinational single restoring iteration. Inputs are partial remainder, next dividend bit and divisor. Outputs are the new partial remainder and the quotient bit. It is instantiated once in `seq_divider`.

## Test plan
- 100 / 7 with W=32 → `done` exactly 33 cycles after `start`; `quotient`=14, `remainder`=2, `div_by_zero`=0.
- 0xFFFFFFFF / 1 → `quotient`=0xFFFFFFFF, `remainder`=0; then 5 / 0xFFFFFFFF → `quotient`=0, `remainder`=5.
- 1234 / 0 → `quotient`=0xFFFFFFFF, `remainder`=1234, `div_by_zero`=1, same latency as a normal divide.
- `start` pulsed at cycle 5 of a running divide with different operands → ignored; first result unchanged. Holding `start` high through the `done` cycle → second divide begins with no idle gap.
- `rst_n` asserted mid-RUN → `busy`, `done` and all results 0 immediately. After release, 9 / 3 → `quotient`=3, `remainder`=0.
- With `SEQ_DIV_SIGNED_EN` and `is_signed`=1:
  - -7 / 2 → `quotient`=-3, `remainder`=-1;
  - 0x80000000 / -1 → `quotient`=0x80000000, `remainder`=0.
